// File: rtl/samcoupe_pkg.sv
// Shared types and defaults for the SAM Coupe RAM arbitration slice.
package samcoupe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } arb_state_t;

  typedef enum logic [1:0] {
    REQ_LD,
    REQ_FDD,
    REQ_CPU
  } req_id_t;

  localparam int TMO_DEFAULT  = 63;
  localparam int FAIR_DEFAULT = 2;

endpackage

// File: rtl/req_latch.sv
// Per-requester pending flag with captured address/data/direction and overrun detect.
module req_latch #(
  parameter int AW = 25
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    din,
  input  logic          clear,
  output logic          pending,
  output logic          we_q,
  output logic [AW-1:0] addr_q,
  output logic [7:0]    din_q,
  output logic          overrun
);

  logic          pending_reg;
  logic          we_reg;
  logic [AW-1:0] addr_reg;
  logic [7:0]    din_reg;

  // A request only lands when idle, so clear and capture never collide.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pending_reg <= 1'b0;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      din_reg     <= '0;
    end else if (req && !pending_reg) begin
      pending_reg <= 1'b1;
      we_reg      <= we;
      addr_reg    <= addr;
      din_reg     <= din;
    end else if (clear) begin
      pending_reg <= 1'b0;
    end
  end

  assign pending = pending_reg;
  assign we_q    = we_reg;
  assign addr_q  = addr_reg;
  assign din_q   = din_reg;
  assign overrun = req & pending_reg;

endmodule

// File: rtl/ram_arbiter.sv
// Three-way RAM port arbiter: loader > floppy > CPU, with a CPU fairness bound and ready timeout.
module ram_arbiter
  import samcoupe_pkg::*;
#(
  parameter int AW   = 25,
  parameter int TMO  = TMO_DEFAULT,
  parameter int FAIR = FAIR_DEFAULT
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_din,
  input  logic          fdd_req,
  input  logic [AW-1:0] fdd_addr,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic          ld_ack,
  output logic          fdd_ack,
  output logic          cpu_ack,
  output logic [7:0]    fdd_dout,
  output logic [7:0]    cpu_dout,
  output logic          cpu_wait,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  output logic          mem_we,
  output logic          mem_rd,
  input  logic          mem_ready,
  input  logic [7:0]    mem_dout,
  output logic          err
);

  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);
  localparam logic [2:0] FAIR_MAX = 3'(FAIR);

  logic [2:0]    req_vec, we_vec, pend_vec, clr_vec, ovr_vec, we_q;
  logic [AW-1:0] addr_in [3];
  logic [AW-1:0] addr_q  [3];
  logic [7:0]    din_in  [3];
  logic [7:0]    din_q   [3];

  assign req_vec = {cpu_req, fdd_req, ld_req};
  assign we_vec  = {cpu_we, 1'b0, 1'b1};
  assign addr_in[REQ_LD]  = ld_addr;
  assign addr_in[REQ_FDD] = fdd_addr;
  assign addr_in[REQ_CPU] = cpu_addr;
  assign din_in[REQ_LD]   = ld_din;
  assign din_in[REQ_FDD]  = 8'h00;
  assign din_in[REQ_CPU]  = cpu_din;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_latch
      req_latch #(.AW(AW)) u_latch (
        .clk_sys (clk_sys),
        .reset   (reset),
        .req     (req_vec[gi]),
        .we      (we_vec[gi]),
        .addr    (addr_in[gi]),
        .din     (din_in[gi]),
        .clear   (clr_vec[gi]),
        .pending (pend_vec[gi]),
        .we_q    (we_q[gi]),
        .addr_q  (addr_q[gi]),
        .din_q   (din_q[gi]),
        .overrun (ovr_vec[gi])
      );
    end
  endgenerate

  arb_state_t    state_reg;
  req_id_t       winner_reg, grant_id;
  logic [2:0]    fair_cnt_reg;
  logic [7:0]    wait_cnt_reg;
  logic [2:0]    ack_reg;
  logic          mem_we_reg, mem_rd_reg, err_reg;
  logic [AW-1:0] mem_addr_reg;
  logic [7:0]    mem_din_reg, fdd_dout_reg, cpu_dout_reg, rd_data;
  logic          timeout_hit, done_enter;

  always_comb begin
    grant_id = REQ_CPU;
    if (pend_vec[REQ_CPU] && fair_cnt_reg == FAIR_MAX) grant_id = REQ_CPU;
    else if (pend_vec[REQ_LD])                          grant_id = REQ_LD;
    else if (pend_vec[REQ_FDD])                         grant_id = REQ_FDD;
  end

  assign timeout_hit = (wait_cnt_reg == TMO_LAST);
  assign done_enter  = (state_reg == ST_WAIT) && (mem_ready || timeout_hit);
  assign rd_data     = mem_ready ? mem_dout : 8'hFF;

  // Pending drops on the same edge the ack rises, which keeps cpu_wait aligned with cpu_ack.
  always_comb begin
    clr_vec = '0;
    if (done_enter) clr_vec[winner_reg] = 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      winner_reg   <= REQ_LD;
      fair_cnt_reg <= '0;
      wait_cnt_reg <= '0;
      ack_reg      <= '0;
      mem_we_reg   <= 1'b0;
      mem_rd_reg   <= 1'b0;
      mem_addr_reg <= '0;
      mem_din_reg  <= '0;
      fdd_dout_reg <= 8'hFF;
      cpu_dout_reg <= 8'hFF;
      err_reg      <= 1'b0;
    end else begin
      ack_reg    <= '0;
      mem_we_reg <= 1'b0;
      mem_rd_reg <= 1'b0;
      if (|ovr_vec) err_reg <= 1'b1;
      if (!pend_vec[REQ_CPU]) fair_cnt_reg <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (|pend_vec) begin
            state_reg    <= ST_ISSUE;
            winner_reg   <= grant_id;
            mem_addr_reg <= addr_q[grant_id];
            mem_din_reg  <= din_q[grant_id];
            mem_we_reg   <= we_q[grant_id];
            mem_rd_reg   <= !we_q[grant_id];
            if (grant_id == REQ_CPU)
              fair_cnt_reg <= '0;
            else if (pend_vec[REQ_CPU] && fair_cnt_reg < FAIR_MAX)
              fair_cnt_reg <= fair_cnt_reg + 3'd1;
          end
        end
        ST_ISSUE: begin
          state_reg    <= ST_WAIT;
          wait_cnt_reg <= '0;
        end
        ST_WAIT: begin
          if (done_enter) begin
            state_reg           <= ST_DONE;
            ack_reg[winner_reg] <= 1'b1;
            if (!mem_ready) err_reg <= 1'b1;
            if (!we_q[winner_reg]) begin
              if (winner_reg == REQ_FDD) fdd_dout_reg <= rd_data;
              if (winner_reg == REQ_CPU) cpu_dout_reg <= rd_data;
            end
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign ld_ack   = ack_reg[REQ_LD];
  assign fdd_ack  = ack_reg[REQ_FDD];
  assign cpu_ack  = ack_reg[REQ_CPU];
  assign fdd_dout = fdd_dout_reg;
  assign cpu_dout = cpu_dout_reg;
  assign cpu_wait = pend_vec[REQ_CPU];
  assign mem_addr = mem_addr_reg;
  assign mem_din  = mem_din_reg;
  assign mem_we   = mem_we_reg;
  assign mem_rd   = mem_rd_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus a randomized run against a RAM model.
module tb_ram_arbiter;

  localparam int AW   = 25;
  localparam int TMO  = 63;
  localparam int FAIR = 2;

  logic          clk_sys, reset;
  logic          ld_req, fdd_req, cpu_req, cpu_we;
  logic [AW-1:0] ld_addr, fdd_addr, cpu_addr;
  logic [7:0]    ld_din, cpu_din;
  logic          ld_ack, fdd_ack, cpu_ack, cpu_wait;
  logic [7:0]    fdd_dout, cpu_dout;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din, mem_dout;
  logic          mem_we, mem_rd, mem_ready, err;

  ram_arbiter #(.AW(AW), .TMO(TMO), .FAIR(FAIR)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_din(ld_din),
    .fdd_req(fdd_req), .fdd_addr(fdd_addr),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .ld_ack(ld_ack), .fdd_ack(fdd_ack), .cpu_ack(cpu_ack),
    .fdd_dout(fdd_dout), .cpu_dout(cpu_dout), .cpu_wait(cpu_wait),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_rd(mem_rd),
    .mem_ready(mem_ready), .mem_dout(mem_dout), .err(err)
  );

  typedef struct {int cyc; bit we; int addr; logic [7:0] din; int gap;} strobe_t;
  typedef struct {int cyc; int who;} ack_t;
  typedef struct {bit busy; bit we; int addr; logic [7:0] din; int req_cyc;} out_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wait_cycles = 0;
  int resp_gap = 0;
  bit resp_rand = 0;
  bit due_valid = 0;
  int due_cyc = 0;
  logic [7:0] due_data = 8'h00;
  logic [7:0] ram [int];
  strobe_t strobes [$];
  ack_t acks [$];

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  initial forever begin
    @(posedge clk_sys);
    cyc++;
  end

  function automatic logic [7:0] ram_rd(input int a);
    if (ram.exists(a)) return ram[a];
    return 8'(a ^ 32'h3C);
  endfunction

  // RAM model: records every strobe, answers reads after resp_gap idle WAIT cycles (negative = never).
  initial begin : monitor
    strobe_t s;
    int g;
    forever begin
      @(negedge clk_sys);
      if (reset) begin
        due_valid = 1'b0;
      end else begin
        if (mem_we || mem_rd) begin
          g = resp_rand ? int'($urandom_range(0, 4)) : resp_gap;
          s.cyc = cyc; s.we = mem_we; s.addr = int'(mem_addr); s.din = mem_din; s.gap = g;
          strobes.push_back(s);
          if (mem_we) ram[s.addr] = mem_din;
          due_valid = (g >= 0);
          due_cyc   = cyc + 1 + g;
          due_data  = ram_rd(s.addr);
        end
        if (ld_ack)  acks.push_back('{cyc, 0});
        if (fdd_ack) acks.push_back('{cyc, 1});
        if (cpu_ack) acks.push_back('{cyc, 2});
        if (cpu_wait) wait_cycles++;
      end
    end
  end

  initial begin : responder
    mem_ready = 1'b0;
    mem_dout  = 8'h00;
    forever begin
      @(posedge clk_sys);
      #1;
      mem_ready = 1'b0;
      if (due_valid && cyc == due_cyc) begin
        mem_ready = 1'b1;
        mem_dout  = due_data;
        due_valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic clear_logs();
    acks.delete();
    strobes.delete();
    wait_cycles = 0;
  endtask

  task automatic wait_acks(input int n, input int budget);
    for (int i = 0; i < budget && acks.size() < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    @(negedge clk_sys);
    checks++;
    if ({ld_ack, fdd_ack, cpu_ack, mem_we, mem_rd} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes got=%b want=00000", {ld_ack, fdd_ack, cpu_ack, mem_we, mem_rd});
    end
    checks++;
    if (mem_addr !== '0 || mem_din !== 8'h00) begin
      errors++; $display("FAIL reset_mem_bus got addr=%h din=%h want 0/0", mem_addr, mem_din);
    end
    checks++;
    if (fdd_dout !== 8'hFF || cpu_dout !== 8'hFF) begin
      errors++; $display("FAIL reset_dout got fdd=%h cpu=%h want ff/ff", fdd_dout, cpu_dout);
    end
    checks++;
    if (cpu_wait !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_flags got wait=%b err=%b want 0/0", cpu_wait, err);
    end
    tick();
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_cpu_read();
    int req_cyc;
    ram[32'h123] = 8'h5A;
    resp_gap = 2;
    clear_logs();
    tick();
    cpu_addr = AW'(32'h123); cpu_we = 1'b0; cpu_req = 1'b1;
    req_cyc = cyc;
    tick();
    cpu_req = 1'b0;
    wait_acks(1, 40);
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (acks.size() !== 1) begin
      errors++; $display("FAIL cpu_read_ack_count got=%0d want=1", acks.size());
    end else begin
      checks++;
      if (acks[0].who !== 2 || acks[0].cyc !== req_cyc + 2 + 2 + resp_gap) begin
        errors++; $display("FAIL cpu_read_ack got who=%0d cyc=%0d want who=2 cyc=%0d",
                           acks[0].who, acks[0].cyc, req_cyc + 4 + resp_gap);
      end
    end
    checks++;
    if (cpu_dout !== 8'h5A) begin
      errors++; $display("FAIL cpu_read_data got=%h want=5a", cpu_dout);
    end
    checks++;
    if (wait_cycles !== 5) begin
      errors++; $display("FAIL cpu_wait_len got=%0d want=5", wait_cycles);
    end
    $display("test_cpu_read addr=123 ack_count=%0d dout=%h", acks.size(), cpu_dout);
  endtask

  task automatic test_ld_cpu_same();
    int a1, a2;
    logic [7:0] d1, d2;
    a1 = int'($urandom_range(0, 255));
    a2 = 32'h200 + int'($urandom_range(0, 255));
    d1 = 8'($urandom);
    d2 = 8'($urandom);
    resp_gap = 0;
    clear_logs();
    tick();
    ld_req = 1'b1; ld_addr = AW'(a1); ld_din = d1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = AW'(a2); cpu_din = d2;
    tick();
    ld_req = 1'b0; cpu_req = 1'b0;
    wait_acks(2, 40);
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (strobes.size() !== 2 || acks.size() !== 2) begin
      errors++; $display("FAIL same_cycle_counts got strobes=%0d acks=%0d want 2/2", strobes.size(), acks.size());
    end else begin
      checks++;
      if (!strobes[0].we || strobes[0].addr !== a1 || strobes[0].din !== d1) begin
        errors++; $display("FAIL same_cycle_first got we=%b addr=%h din=%h want 1/%h/%h",
                           strobes[0].we, strobes[0].addr, strobes[0].din, a1, d1);
      end
      checks++;
      if (!strobes[1].we || strobes[1].addr !== a2 || strobes[1].din !== d2) begin
        errors++; $display("FAIL same_cycle_second got we=%b addr=%h din=%h want 1/%h/%h",
                           strobes[1].we, strobes[1].addr, strobes[1].din, a2, d2);
      end
      checks++;
      if (acks[0].who !== 0 || acks[1].who !== 2 || strobes[1].cyc !== acks[0].cyc + 2) begin
        errors++; $display("FAIL same_cycle_order got who=%0d,%0d cpu_issue=%0d want 0,2 issue=%0d",
                           acks[0].who, acks[1].who, strobes[1].cyc, acks[0].cyc + 2);
      end
    end
    $display("test_ld_cpu_same ld=%h/%h cpu=%h/%h", a1, d1, a2, d2);
  endtask

  task automatic test_fair();
    int fa, ca, run, exp_addr;
    fa = 32'h100 + int'($urandom_range(0, 255));
    ca = 32'h200 + int'($urandom_range(0, 255));
    resp_gap = 1;
    clear_logs();
    tick();
    fdd_req = 1'b1; fdd_addr = AW'(fa);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(ca);
    tick();
    // Both requesters re-request in their own DONE cycle, so both stay pending throughout.
    for (int i = 0; i < 200 && acks.size() < 6; i++) begin
      fdd_req = fdd_ack;
      cpu_req = cpu_ack;
      tick();
    end
    fdd_req = 1'b0; cpu_req = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    checks++;
    if (strobes.size() < 6) begin
      errors++; $display("FAIL fair_grants got=%0d want>=6", strobes.size());
    end else begin
      run = 0;
      for (int g = 0; g < 6; g++) begin
        if (run == FAIR) begin exp_addr = ca; run = 0; end
        else begin exp_addr = fa; run++; end
        checks++;
        if (strobes[g].addr !== exp_addr) begin
          errors++; $display("FAIL fair_grant_%0d got addr=%h want=%h", g, strobes[g].addr, exp_addr);
        end
      end
    end
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL fair_err got=%b want=0", err);
    end
    $display("test_fair grants=%0d fdd=%h cpu=%h", strobes.size(), fa, ca);
  endtask

  task automatic test_timeout();
    int req_cyc;
    ram[32'h155] = 8'h11;
    ram[32'h277] = 8'h77;
    resp_gap = 0;
    clear_logs();
    tick();
    fdd_req = 1'b1; fdd_addr = AW'(32'h155);
    tick();
    fdd_req = 1'b0;
    wait_acks(1, 40);
    tick();
    checks++;
    if (fdd_dout !== 8'h11) begin
      errors++; $display("FAIL fdd_read_data got=%h want=11", fdd_dout);
    end
    resp_gap = -1;
    clear_logs();
    fdd_req = 1'b1; fdd_addr = AW'(32'h166);
    tick();
    fdd_req = 1'b0;
    wait_acks(1, 200);
    tick();
    checks++;
    if (acks.size() !== 1 || strobes.size() !== 1) begin
      errors++; $display("FAIL timeout_ack got acks=%0d strobes=%0d want 1/1", acks.size(), strobes.size());
    end else begin
      checks++;
      if (acks[0].cyc - strobes[0].cyc !== TMO + 1) begin
        errors++; $display("FAIL timeout_len got=%0d want=%0d", acks[0].cyc - strobes[0].cyc, TMO + 1);
      end
    end
    checks++;
    if (fdd_dout !== 8'hFF || err !== 1'b1) begin
      errors++; $display("FAIL timeout_result got dout=%h err=%b want ff/1", fdd_dout, err);
    end
    resp_gap = 0;
    clear_logs();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(32'h277);
    req_cyc = cyc;
    tick();
    cpu_req = 1'b0;
    wait_acks(1, 40);
    tick();
    checks++;
    if (acks.size() !== 1 || cpu_dout !== 8'h77 || err !== 1'b1) begin
      errors++; $display("FAIL timeout_after got acks=%0d dout=%h err=%b want 1/77/1", acks.size(), cpu_dout, err);
    end
    $display("test_timeout recovery_req_cyc=%0d", req_cyc);
  endtask

  task automatic test_overrun();
    int a, b;
    logic [7:0] da, db;
    a = 32'h200 + int'($urandom_range(0, 127));
    b = a + 128;
    da = 8'($urandom);
    db = ~da;
    do_reset();
    resp_gap = 4;
    clear_logs();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = AW'(a); cpu_din = da;
    tick();
    cpu_req = 1'b0;
    tick();
    cpu_req = 1'b1; cpu_addr = AW'(b); cpu_din = db;
    tick();
    cpu_req = 1'b0;
    wait_acks(1, 40);
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL overrun_err got=%b want=1", err);
    end
    checks++;
    if (acks.size() !== 1 || strobes.size() !== 1) begin
      errors++; $display("FAIL overrun_count got acks=%0d strobes=%0d want 1/1", acks.size(), strobes.size());
    end else begin
      checks++;
      if (strobes[0].addr !== a || strobes[0].din !== da) begin
        errors++; $display("FAIL overrun_fields got addr=%h din=%h want %h/%h", strobes[0].addr, strobes[0].din, a, da);
      end
    end
    $display("test_overrun first=%h second=%h", a, b);
  endtask

  task automatic test_reset_wait();
    int req_cyc;
    resp_gap = -1;
    clear_logs();
    fdd_req = 1'b1; fdd_addr = AW'(32'h1AB);
    tick();
    fdd_req = 1'b0;
    for (int i = 0; i < 20 && strobes.size() == 0; i++) tick();
    tick();
    tick();
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(32'h2CD);
    tick();
    reset = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk_sys);
    checks++;
    if ({ld_ack, fdd_ack, cpu_ack, mem_we, mem_rd, cpu_wait, err} !== 7'b0 ||
        mem_addr !== '0 || fdd_dout !== 8'hFF || cpu_dout !== 8'hFF) begin
      errors++; $display("FAIL reset_in_wait got flags=%b addr=%h fdd=%h cpu=%h want 0/0/ff/ff",
                         {ld_ack, fdd_ack, cpu_ack, mem_we, mem_rd, cpu_wait, err}, mem_addr, fdd_dout, cpu_dout);
    end
    for (int i = 0; i < 80; i++) tick();
    checks++;
    if (acks.size() !== 0 || strobes.size() !== 1) begin
      errors++; $display("FAIL reset_abandon got acks=%0d strobes=%0d want 0/1", acks.size(), strobes.size());
    end
    ram[32'h2AA] = 8'h3E;
    resp_gap = 0;
    clear_logs();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(32'h2AA);
    req_cyc = cyc;
    tick();
    cpu_req = 1'b0;
    wait_acks(1, 40);
    tick();
    checks++;
    if (acks.size() !== 1) begin
      errors++; $display("FAIL reset_next_ack got=%0d want=1", acks.size());
    end else begin
      checks++;
      if (acks[0].cyc - req_cyc !== 4 || cpu_dout !== 8'h3E) begin
        errors++; $display("FAIL reset_next got latency=%0d dout=%h want 4/3e", acks[0].cyc - req_cyc, cpu_dout);
      end
    end
    $display("test_reset_wait next_latency_req_cyc=%0d", req_cyc);
  endtask

  task automatic test_random();
    out_t outs [3];
    logic [2:0] fire, ack_vec;
    strobe_t s;
    logic [7:0] got, expv;
    int n_tr;
    n_tr = 0;
    do_reset();
    clear_logs();
    resp_rand = 1'b1;
    for (int r = 0; r < 3; r++) outs[r].busy = 1'b0;
    for (int c = 0; c < 800; c++) begin
      tick();
      fire = '0;
      for (int r = 0; r < 3; r++) begin
        if (c < 600 && !outs[r].busy && $urandom_range(0, 3) == 0) begin
          outs[r].busy    = 1'b1;
          outs[r].we      = (r == 0) ? 1'b1 : (r == 1) ? 1'b0 : 1'($urandom_range(0, 1));
          outs[r].addr    = r * 256 + int'($urandom_range(0, 255));
          outs[r].din     = (r == 1) ? 8'h00 : 8'($urandom);
          outs[r].req_cyc = cyc;
          fire[r] = 1'b1;
        end
      end
      ld_req  = fire[0]; ld_addr  = AW'(outs[0].addr); ld_din = outs[0].din;
      fdd_req = fire[1]; fdd_addr = AW'(outs[1].addr);
      cpu_req = fire[2]; cpu_we   = outs[2].we; cpu_addr = AW'(outs[2].addr); cpu_din = outs[2].din;
      @(negedge clk_sys);
      checks++;
      if (cpu_wait !== (outs[2].busy && cyc > outs[2].req_cyc && !cpu_ack)) begin
        errors++; $display("FAIL rnd_cpu_wait cyc=%0d got=%b want=%b", cyc, cpu_wait,
                           outs[2].busy && cyc > outs[2].req_cyc && !cpu_ack);
      end
      ack_vec = {cpu_ack, fdd_ack, ld_ack};
      for (int r = 0; r < 3; r++) begin
        if (ack_vec[r]) begin
          checks++;
          if (!outs[r].busy || strobes.size() == 0) begin
            errors++; $display("FAIL rnd_ack_unexpected who=%0d cyc=%0d got ack want none", r, cyc);
          end else begin
            s = strobes[$];
            checks++;
            if (s.addr !== outs[r].addr || s.we !== outs[r].we || (s.we && s.din !== outs[r].din)) begin
              errors++; $display("FAIL rnd_issue who=%0d got we=%b addr=%h din=%h want %b/%h/%h",
                                 r, s.we, s.addr, s.din, outs[r].we, outs[r].addr, outs[r].din);
            end
            checks++;
            if (cyc !== s.cyc + 2 + s.gap) begin
              errors++; $display("FAIL rnd_latency who=%0d got=%0d want=%0d", r, cyc, s.cyc + 2 + s.gap);
            end
            if (!outs[r].we) begin
              got  = (r == 1) ? fdd_dout : cpu_dout;
              expv = ram_rd(outs[r].addr);
              checks++;
              if (got !== expv) begin
                errors++; $display("FAIL rnd_read who=%0d addr=%h got=%h want=%h", r, outs[r].addr, got, expv);
              end
            end
            $display("rnd who=%0d we=%b addr=%h cyc=%0d", r, outs[r].we, outs[r].addr, cyc);
            n_tr++;
          end
          outs[r].busy = 1'b0;
        end
      end
    end
    ld_req = 1'b0; fdd_req = 1'b0; cpu_req = 1'b0;
    resp_rand = 1'b0;
    checks++;
    if (outs[0].busy || outs[1].busy || outs[2].busy || err !== 1'b0) begin
      errors++; $display("FAIL rnd_drain got busy=%b%b%b err=%b want 000/0",
                         outs[0].busy, outs[1].busy, outs[2].busy, err);
    end
    $display("test_random transactions=%0d", n_tr);
  endtask

  initial begin
    reset = 1'b1;
    ld_req = 1'b0; fdd_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    ld_addr = '0; fdd_addr = '0; cpu_addr = '0;
    ld_din = 8'h00; cpu_din = 8'h00;
    test_reset();
    test_cpu_read();
    test_ld_cpu_same();
    test_fair();
    test_timeout();
    test_overrun();
    test_reset_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter AW, default 25: byte address width of all address ports.
REQ-002 Parameter TMO, default 63: mem_ready timeout in clk_sys cycles, range 1..255.
REQ-003 Parameter FAIR, default 2: consecutive non-CPU grants allowed while CPU pending, range 1..7.
REQ-004 clk_sys  in  1  system clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 ld_req/ld_addr/ld_din  in  1/AW/8  loader write request pulse, address, data.
REQ-007 fdd_req/fdd_addr  in  1/AW  floppy buffer read request pulse, address.
REQ-008 cpu_req/cpu_we/cpu_addr/cpu_din  in  1/1/AW/8  CPU access request pulse, write flag, address, data.
REQ-009 ld_ack, fdd_ack, cpu_ack  out  1 each  one-cycle completion pulses.
REQ-010 fdd_dout, cpu_dout  out  8 each  read data, valid from ack until next ack of same requester.
REQ-011 cpu_wait  out  1  high while a CPU access is pending and not yet acked.
REQ-012 mem_addr/mem_din/mem_we/mem_rd  out  AW/8/1/1  RAM port; we/rd are one-cycle strobes.
REQ-013 mem_ready/mem_dout  in  1/8  RAM completion pulse and read data, valid with mem_ready.
REQ-014 err  out  1  sticky: timeout or request overrun occurred.

Function
REQ-015 A req pulse sets that requester's pending flag and captures address/data/we in the same cycle.
REQ-016 A req pulse while already pending is dropped, sets err; captured fields stay unchanged.
REQ-017 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-018 IDLE: with any pending, select winner and go ISSUE next cycle; else stay.
REQ-019 Priority: loader > FDD > CPU, except CPU wins when CPU pending and fair_cnt == FAIR.
REQ-020 fair_cnt (3 bits) increments on each non-CPU grant while CPU pending, clears on CPU grant or when CPU not pending; saturates at FAIR.
REQ-021 ISSUE: drive mem_addr/mem_din from winner, pulse mem_we (loader, CPU write) or mem_rd (FDD, CPU read) for exactly one cycle, go WAIT.
REQ-022 WAIT: on mem_ready latch mem_dout into winner's dout (reads only), go DONE; mem_addr/mem_din held stable throughout WAIT.
REQ-023 WAIT: after TMO cycles without mem_ready, go DONE, winner dout = 8'hFF for reads, set err.
REQ-024 DONE: pulse winner's ack, clear its pending flag, return IDLE; minimum request-to-ack latency 4 cycles with mem_ready in first WAIT cycle.
REQ-025 A new req from the winner arriving in DONE is accepted (pending re-set after clear).
REQ-026 mem_ready outside WAIT is ignored.
REQ-027 cpu_wait = cpu pending flag, registered; drops in same cycle cpu_ack rises.

Reset
REQ-028 On reset: FSM IDLE, all pending flags 0, all acks 0, mem_we/mem_rd 0, mem_addr 0, mem_din 0, fdd_dout/cpu_dout 8'hFF, cpu_wait 0, fair_cnt 0, err 0.
REQ-029 Reset mid-access abandons the access with no ack; reqs coincident with reset are dropped.

Structure
REQ-030 Shared package samcoupe_pkg holds FSM state enum, requester-id enum (REQ_LD, REQ_FDD, REQ_CPU) and default TMO/FAIR constants.
REQ-031 One sub-module req_latch (pending flag, captured fields, overrun detect), instantiated once per requester.

Verification
REQ-032 CPU read 0x00123, mem_ready 2 cycles after mem_rd, mem_dout 0x5A -> cpu_ack once, cpu_dout 0x5A, cpu_wait high 5 cycles.
REQ-033 ld_req and cpu_req same cycle -> loader issued first (mem_we, ld_din), CPU issued immediately after ld_ack.
REQ-034 FDD requests back-to-back, CPU pending, FAIR=2 -> third grant goes to CPU; fair_cnt returns 0.
REQ-035 mem_ready withheld, TMO=63 -> ack 63 WAIT cycles after issue, dout 0xFF, err 1 until reset.
REQ-036 Second cpu_req while pending -> err 1, single cpu_ack, original address used.
REQ-037 reset asserted in WAIT -> no ack, outputs at REQ-028 values next cycle; next request served normally.
